// File: rtl/mips_div_unit.sv
// mips_div_unit: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU
//   clk           in   clock, rising edge
//   resetn        in   asynchronous active-low reset
//   a, b          in   dividend / divisor, sampled on an accepted start
//   div_signed    in   1 = signed DIV, 0 = DIVU, sampled with a/b
//   start         in   request pulse, accepted in IDLE when cancel is low
//   cancel        in   aborts an operation in CALC or FIX
//   busy          out  high whenever not IDLE
//   result_valid  out  one-cycle pulse presenting hi/lo/div_by_zero
//   hi, lo        out  remainder / quotient, held until the next result
//   div_by_zero   out  set when the last result came from a zero divisor
module mips_div_unit #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] DIV0_LO = '1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              div_signed,
    input  logic              start,
    input  logic              cancel,
    output logic              busy,
    output logic              result_valid,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              div_by_zero
);
    localparam int CW = $clog2(DATA_W);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] rem, quo, dvs, abs_a, abs_b;
    logic [DATA_W:0] sh, df;
    logic sign_q, sign_r, take, go;
    assign go = state == IDLE && start && !cancel;
    assign abs_a = (div_signed && a[DATA_W-1]) ? -a : a;
    assign abs_b = (div_signed && b[DATA_W-1]) ? -b : b;
    assign sh = {rem, quo[DATA_W-1]};
    // sh < 2*dvs, so the borrow bit of the trial subtraction is exactly sh < dvs
    assign df = sh - {1'b0, dvs};
    assign take = ~df[DATA_W];
    assign busy = state != IDLE;
    assign result_valid = state == DONE;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = go ? ((b == '0) ? DONE : CALC) : IDLE;
            CALC:    state_nx = cancel ? IDLE : (cnt == CW'(DATA_W - 1)) ? FIX : CALC;
            FIX:     state_nx = cancel ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (go && b == '0) begin
                lo          <= DIV0_LO;
                hi          <= a;
                div_by_zero <= 1'b1;
            end else if (go) begin
                rem    <= '0;
                quo    <= abs_a;
                dvs    <= abs_b;
                cnt    <= '0;
                sign_q <= div_signed & (a[DATA_W-1] ^ b[DATA_W-1]);
                sign_r <= div_signed & a[DATA_W-1];
            end
            if (state == CALC) begin
                rem <= take ? df[DATA_W-1:0] : sh[DATA_W-1:0];
                quo <= {quo[DATA_W-2:0], take};
                cnt <= cnt + CW'(1);
            end
            if (state == FIX && !cancel) begin
                lo          <= sign_q ? -quo : quo;
                hi          <= sign_r ? -rem : rem;
                div_by_zero <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mips_div_unit.sv
// tb_mips_div_unit: randomized self-checking bench for mips_div_unit
module tb_mips_div_unit;
    logic clk = 0, resetn = 0, div_signed = 0, start = 0, cancel = 0;
    logic [31:0] a = 0, b = 0;
    logic busy, result_valid, div_by_zero;
    logic [31:0] hi, lo;
    logic [31:0] last_hi = 0, last_lo = 0;
    logic last_dbz = 0;
    int total = 0, bad = 0;

    mips_div_unit dut (
        .clk(clk), .resetn(resetn), .a(a), .b(b), .div_signed(div_signed),
        .start(start), .cancel(cancel), .busy(busy), .result_valid(result_valid),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [31:0] x, input logic [31:0] y, input logic s,
                         output logic [31:0] eh, output logic [31:0] el, output logic ed);
        ed = (y == 0);
        if (y == 0) begin
            el = 32'hFFFF_FFFF;
            eh = x;
        end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            el = x;
            eh = 0;
        end else if (s) begin
            el = $signed(x) / $signed(y);
            eh = $signed(x) % $signed(y);
        end else begin
            el = x / y;
            eh = x % y;
        end
    endtask

    task automatic no_result(input int n);
        int seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (result_valid) seen++;
        end
        check("stray_rv", 32'(seen), 0);
    endtask

    // ck: wait index at which cancel is pulsed; jk: index of an ignored start
    task automatic op(input logic [31:0] x, input logic [31:0] y, input logic s,
                      input int ck, input int jk);
        logic [31:0] eh, el;
        logic ed;
        int lat, got;
        model(x, y, s, eh, el, ed);
        lat = (y == 0) ? 0 : 33;
        got = -1;
        @(negedge clk);
        a = x; b = y; div_signed = s; start = 1;
        @(negedge clk);
        start = 0; a = $urandom; b = $urandom; div_signed = 1'($urandom);
        check("busy_run", 32'(busy), 1);
        for (int k = 0; k < 40; k++) begin
            if (result_valid) begin
                got = k;
                break;
            end
            start = (k == jk);
            cancel = (k == ck);
            if (start) begin a = $urandom; b = $urandom; end
            @(negedge clk);
            start = 0;
            cancel = 0;
            if (k == ck) break;
        end
        if (ck >= 0 && ck < lat) begin
            check("cancel_busy", 32'(busy), 0);
            check("cancel_hi", hi, last_hi);
            check("cancel_lo", lo, last_lo);
            check("cancel_dbz", 32'(div_by_zero), 32'(last_dbz));
            no_result(40);
        end else begin
            check("latency", 32'(got), 32'(lat));
            check("hi", hi, eh);
            check("lo", lo, el);
            check("dbz", 32'(div_by_zero), 32'(ed));
            last_hi = eh; last_lo = el; last_dbz = ed;
            @(negedge clk);
            check("pulse_end", 32'(result_valid), 0);
            check("idle_after", 32'(busy), 0);
        end
    endtask

    initial begin
        logic [31:0] x, y;
        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_rv", 32'(result_valid), 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_dbz", 32'(div_by_zero), 0);
        @(negedge clk);
        resetn = 1;
        op(100, 7, 0, -1, -1);
        op(32'hFFFF_FFF9, 2, 1, -1, -1);
        op(7, 32'hFFFF_FFFE, 1, -1, -1);
        op(32'h8000_0000, 32'hFFFF_FFFF, 1, -1, -1);
        op(32'h8000_0000, 32'hFFFF_FFFF, 0, -1, -1);
        op(5, 0, 0, -1, -1);
        op(9, 3, 0, -1, -1);
        op(12345, 67, 0, 10, -1);
        op(9, 3, 0, -1, -1);
        op(32'hFFFF_FC18, 10, 1, -1, 5);
        op(77, 5, 1, 32, -1);
        op(77, 5, 1, 33, -1);
        @(negedge clk);
        a = 40; b = 4; start = 1; cancel = 1;
        @(negedge clk);
        start = 0; cancel = 0;
        check("idle_cancel_blocks", 32'(busy), 0);
        no_result(40);
        @(negedge clk);
        a = 50000; b = 7; div_signed = 0; start = 1;
        @(negedge clk);
        start = 0;
        repeat (19) @(negedge clk);
        #1 resetn = 0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_rv", 32'(result_valid), 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        check("arst_dbz", 32'(div_by_zero), 0);
        last_hi = 0; last_lo = 0; last_dbz = 0;
        @(negedge clk);
        resetn = 1;
        no_result(40);
        op(1000, 33, 0, -1, -1);
        for (int i = 0; i < 40; i++) begin
            x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0:       y = 0;
                1:       y = $urandom_range(1, 20);
                2:       y = 32'(0 - $urandom_range(1, 20));
                3:       y = 32'hFFFF_FFFF;
                default: y = $urandom;
            endcase
            op(x, y, 1'($urandom), ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 32)) : -1, -1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
